// File: rtl/issue_scoreboard_if.sv
// Issue-stage bus between the decode front end and the register scoreboard.
// StallCount exists only when ISSUE_STALL_COUNTER_EN is defined.
interface issue_scoreboard_if #(
   parameter int DATABITWIDTH    = 16,
   parameter int TAGBITWIDTH     = 6,
   parameter int REGADDRBITWIDTH = 4,
   parameter int FUNITCOUNT      = 5
);
   localparam int REGCOUNT = 2 ** REGADDRBITWIDTH;

   logic                       InstValid;
   logic [3:0]                 MinorOpcode;
   logic [FUNITCOUNT-1:0]      FunctionalUnitEnable;
   logic [1:0]                 WriteBackSourceIn;
   logic [TAGBITWIDTH-1:0]     InstructionTagIn;
   logic                       WritebackEnIn;
   logic [REGADDRBITWIDTH-1:0] WritebackRegAddr;
   logic                       RegAReadEn;
   logic                       RegBReadEn;
   logic [REGADDRBITWIDTH-1:0] RegAAddr;
   logic [REGADDRBITWIDTH-1:0] RegBAddr;
   logic [DATABITWIDTH-1:0]    RegADataIn;
   logic [DATABITWIDTH-1:0]    RegBDataIn;
   logic [FUNITCOUNT-1:0]      FunctionalUnitReady;
   logic                       CompleteValid;
   logic [REGADDRBITWIDTH-1:0] CompleteRegAddr;

   logic                       IssueStallOut;
   logic                       IssueValid;
   logic [FUNITCOUNT-1:0]      FunctionalUnitIssue;
   logic [3:0]                 ALU_MinorOpcode;
   logic [DATABITWIDTH-1:0]    Data_A;
   logic [DATABITWIDTH-1:0]    Data_B;
   logic [TAGBITWIDTH-1:0]     IssueTagOut;
   logic                       RegWriteEn;
   logic [1:0]                 WriteBackSourceOut;
   logic [REGADDRBITWIDTH-1:0] RegWriteAddrOut;
   logic [REGCOUNT-1:0]        PendingMask;
`ifdef ISSUE_STALL_COUNTER_EN
   logic [15:0]                StallCount;
`endif

   modport master (
      output InstValid, MinorOpcode, FunctionalUnitEnable, WriteBackSourceIn,
             InstructionTagIn, WritebackEnIn, WritebackRegAddr, RegAReadEn,
             RegBReadEn, RegAAddr, RegBAddr, RegADataIn, RegBDataIn,
             FunctionalUnitReady, CompleteValid, CompleteRegAddr,
`ifdef ISSUE_STALL_COUNTER_EN
      input  StallCount,
`endif
      input  IssueStallOut, IssueValid, FunctionalUnitIssue, ALU_MinorOpcode,
             Data_A, Data_B, IssueTagOut, RegWriteEn, WriteBackSourceOut,
             RegWriteAddrOut, PendingMask
   );

   modport slave (
      input  InstValid, MinorOpcode, FunctionalUnitEnable, WriteBackSourceIn,
             InstructionTagIn, WritebackEnIn, WritebackRegAddr, RegAReadEn,
             RegBReadEn, RegAAddr, RegBAddr, RegADataIn, RegBDataIn,
             FunctionalUnitReady, CompleteValid, CompleteRegAddr,
`ifdef ISSUE_STALL_COUNTER_EN
      output StallCount,
`endif
      output IssueStallOut, IssueValid, FunctionalUnitIssue, ALU_MinorOpcode,
             Data_A, Data_B, IssueTagOut, RegWriteEn, WriteBackSourceOut,
             RegWriteAddrOut, PendingMask
   );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue stage with a per-register pending-write scoreboard.
// Optional saturating stall counter enabled by ISSUE_STALL_COUNTER_EN.
module issue_scoreboard #(
   parameter int DATABITWIDTH    = 16,
   parameter int TAGBITWIDTH     = 6,
   parameter int REGADDRBITWIDTH = 4,
   parameter int FUNITCOUNT      = 5
) (
   input logic               clk,
   input logic               sync_rst,
   input logic               clk_en,
   issue_scoreboard_if.slave bus
);
   localparam int REGCOUNT = 2 ** REGADDRBITWIDTH;

   logic [REGCOUNT-1:0]        pending;
   logic [REGCOUNT-1:0]        pendingNext;
   logic [REGCOUNT-1:0]        setMask;
   logic [REGCOUNT-1:0]        clrMask;
   logic                       hazard;
   logic                       unitsReady;
   logic                       fire;
   logic                       issueStall;

   logic                       issueValidQ;
   logic [FUNITCOUNT-1:0]      fuIssueQ;
   logic [3:0]                 opcodeQ;
   logic [DATABITWIDTH-1:0]    dataAQ;
   logic [DATABITWIDTH-1:0]    dataBQ;
   logic [TAGBITWIDTH-1:0]     tagQ;
   logic                       regWriteEnQ;
   logic [1:0]                 wbSrcQ;
   logic [REGADDRBITWIDTH-1:0] wrAddrQ;

   // Hazards look only at registered pending bits; a completion is not bypassed.
   always_comb begin
      hazard = (bus.RegAReadEn    & pending[bus.RegAAddr])
             | (bus.RegBReadEn    & pending[bus.RegBAddr])
             | (bus.WritebackEnIn & pending[bus.WritebackRegAddr]);
      unitsReady = &(bus.FunctionalUnitReady | ~bus.FunctionalUnitEnable);
      fire       = clk_en & bus.InstValid & ~hazard & unitsReady;
      issueStall = bus.InstValid & ~fire;
   end

   // Clear is applied before set so a same-cycle set/clear of one register leaves it set.
   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (fire && bus.WritebackEnIn) setMask[bus.WritebackRegAddr] = 1'b1;
      if (bus.CompleteValid)         clrMask[bus.CompleteRegAddr]  = 1'b1;
      pendingNext = (pending & ~clrMask) | setMask;
   end

   always_ff @(posedge clk) begin
      if (!sync_rst) begin
         pending     <= '0;
         issueValidQ <= 1'b0;
         fuIssueQ    <= '0;
         regWriteEnQ <= 1'b0;
         opcodeQ     <= '0;
         dataAQ      <= '0;
         dataBQ      <= '0;
         tagQ        <= '0;
         wbSrcQ      <= '0;
         wrAddrQ     <= '0;
      end else if (clk_en) begin
         pending     <= pendingNext;
         issueValidQ <= fire;
         fuIssueQ    <= fire ? bus.FunctionalUnitEnable : '0;
         regWriteEnQ <= fire & bus.WritebackEnIn;
         if (fire) begin
            opcodeQ <= bus.MinorOpcode;
            dataAQ  <= bus.RegADataIn;
            dataBQ  <= bus.RegBDataIn;
            tagQ    <= bus.InstructionTagIn;
            wbSrcQ  <= bus.WriteBackSourceIn;
            wrAddrQ <= bus.WritebackRegAddr;
         end
      end
   end

`ifdef ISSUE_STALL_COUNTER_EN
   logic [15:0] stallCountQ;

   always_ff @(posedge clk) begin
      if (!sync_rst) begin
         stallCountQ <= '0;
      end else if (clk_en && issueStall && (stallCountQ != 16'hFFFF)) begin
         stallCountQ <= stallCountQ + 16'd1;
      end
   end

   assign bus.StallCount = stallCountQ;
`endif

   assign bus.IssueStallOut      = issueStall;
   assign bus.IssueValid         = issueValidQ;
   assign bus.FunctionalUnitIssue = fuIssueQ;
   assign bus.ALU_MinorOpcode    = opcodeQ;
   assign bus.Data_A             = dataAQ;
   assign bus.Data_B             = dataBQ;
   assign bus.IssueTagOut        = tagQ;
   assign bus.RegWriteEn         = regWriteEnQ;
   assign bus.WriteBackSourceOut = wbSrcQ;
   assign bus.RegWriteAddrOut    = wrAddrQ;
   assign bus.PendingMask        = pending;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard against a behavioural scoreboard model.
// StallCount checks are compiled in when ISSUE_STALL_COUNTER_EN is defined.
module tb_issue_scoreboard;
   logic clk;
   logic sync_rst;
   logic clk_en;

   int checks;
   int errors;

   issue_scoreboard_if #(.DATABITWIDTH(16), .TAGBITWIDTH(6), .REGADDRBITWIDTH(4), .FUNITCOUNT(5)) bus ();

   issue_scoreboard #(.DATABITWIDTH(16), .TAGBITWIDTH(6), .REGADDRBITWIDTH(4), .FUNITCOUNT(5)) dut (
      .clk(clk),
      .sync_rst(sync_rst),
      .clk_en(clk_en),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a plain array of "register awaits writeback" flags plus expected outputs.
   bit          modelPend [16];
   logic        expIssueValid;
   logic [4:0]  expFuIssue;
   logic [3:0]  expOpcode;
   logic [15:0] expDataA;
   logic [15:0] expDataB;
   logic [5:0]  expTag;
   logic        expWrEn;
   logic [1:0]  expWbSrc;
   logic [3:0]  expWrAddr;
   int          expStallCount;
   bit          predFire;
   bit          predStall;

   function automatic logic [15:0] modelMask();
      logic [15:0] m;
      m = '0;
      for (int r = 0; r < 16; r++) if (modelPend[r]) m[r] = 1'b1;
      return m;
   endfunction

   task automatic predict();
      bit hz;
      bit rdy;
      hz = (bus.RegAReadEn && modelPend[bus.RegAAddr]) ||
           (bus.RegBReadEn && modelPend[bus.RegBAddr]) ||
           (bus.WritebackEnIn && modelPend[bus.WritebackRegAddr]);
      rdy = 1'b1;
      for (int u = 0; u < 5; u++)
         if (bus.FunctionalUnitEnable[u] && !bus.FunctionalUnitReady[u]) rdy = 1'b0;
      predFire  = clk_en && bus.InstValid && !hz && rdy;
      predStall = bus.InstValid && !predFire;
   endtask

   task automatic tick();
      predict();
      @(posedge clk);
      if (!sync_rst) begin
         for (int r = 0; r < 16; r++) modelPend[r] = 1'b0;
         expIssueValid = 0; expFuIssue = '0; expOpcode = '0; expDataA = '0; expDataB = '0;
         expTag = '0; expWrEn = 0; expWbSrc = '0; expWrAddr = '0; expStallCount = 0;
      end else if (clk_en) begin
         if (predStall && expStallCount < 65535) expStallCount++;
         if (bus.CompleteValid) modelPend[bus.CompleteRegAddr] = 1'b0;
         if (predFire && bus.WritebackEnIn) modelPend[bus.WritebackRegAddr] = 1'b1;
         expIssueValid = predFire;
         expFuIssue    = predFire ? bus.FunctionalUnitEnable : 5'b0;
         expWrEn       = predFire && bus.WritebackEnIn;
         if (predFire) begin
            expOpcode = bus.MinorOpcode;      expDataA = bus.RegADataIn;
            expDataB  = bus.RegBDataIn;       expTag   = bus.InstructionTagIn;
            expWbSrc  = bus.WriteBackSourceIn; expWrAddr = bus.WritebackRegAddr;
         end
      end
      #1;
   endtask

   task automatic applyStimulus();
      bus.InstValid = 0; bus.MinorOpcode = '0; bus.FunctionalUnitEnable = '0;
      bus.WriteBackSourceIn = '0; bus.InstructionTagIn = '0; bus.WritebackEnIn = 0;
      bus.WritebackRegAddr = '0; bus.RegAReadEn = 0; bus.RegBReadEn = 0;
      bus.RegAAddr = '0; bus.RegBAddr = '0; bus.RegADataIn = '0; bus.RegBDataIn = '0;
      bus.FunctionalUnitReady = 5'b11111; bus.CompleteValid = 0; bus.CompleteRegAddr = '0;
   endtask

   task automatic test_reset();
      applyStimulus();
      sync_rst = 0; clk_en = 0;
      tick(); tick();
      checks += 4;
      if (bus.IssueValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", bus.IssueValid); end
      if (bus.FunctionalUnitIssue !== 5'b0) begin errors++; $display("[TB] FAIL reset_fu: got %0h expected 0", bus.FunctionalUnitIssue); end
      if (bus.PendingMask !== 16'h0) begin errors++; $display("[TB] FAIL reset_mask: got %0h expected 0", bus.PendingMask); end
      if (bus.Data_A !== 16'h0 || bus.IssueTagOut !== 6'h0 || bus.RegWriteEn !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_payload: got A=%0h tag=%0h we=%0h expected 0", bus.Data_A, bus.IssueTagOut, bus.RegWriteEn);
      end
      sync_rst = 1; clk_en = 1;
   endtask

   task automatic test_basic_issue();
      applyStimulus();
      bus.InstValid = 1; bus.WritebackEnIn = 1; bus.WritebackRegAddr = 4'd3;
      bus.FunctionalUnitEnable = 5'b00001; bus.MinorOpcode = 4'hA;
      bus.RegADataIn = 16'($urandom); bus.RegBDataIn = 16'($urandom); bus.InstructionTagIn = 6'h2D;
      #1;
      checks++;
      if (bus.IssueStallOut !== 1'b0) begin errors++; $display("[TB] FAIL basic_stall: got %0h expected 0", bus.IssueStallOut); end
      tick();
      applyStimulus();
      checks += 5;
      if (bus.IssueValid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %0h expected 1", bus.IssueValid); end
      if (bus.FunctionalUnitIssue !== 5'b00001) begin errors++; $display("[TB] FAIL basic_fu: got %0h expected 1", bus.FunctionalUnitIssue); end
      if (bus.PendingMask !== 16'h0008) begin errors++; $display("[TB] FAIL basic_mask: got %0h expected 8", bus.PendingMask); end
      if (bus.Data_A !== expDataA || bus.Data_B !== expDataB) begin
         errors++; $display("[TB] FAIL basic_data: got %0h/%0h expected %0h/%0h", bus.Data_A, bus.Data_B, expDataA, expDataB);
      end
      if (bus.IssueTagOut !== 6'h2D || bus.ALU_MinorOpcode !== 4'hA || bus.RegWriteAddrOut !== 4'd3) begin
         errors++; $display("[TB] FAIL basic_payload: got tag=%0h op=%0h wa=%0h expected 2d/a/3", bus.IssueTagOut, bus.ALU_MinorOpcode, bus.RegWriteAddrOut);
      end
   endtask

   task automatic test_hazard_complete();
      applyStimulus();
      bus.InstValid = 1; bus.RegAReadEn = 1; bus.RegAAddr = 4'd3; bus.FunctionalUnitEnable = 5'b00010;
      #1;
      checks += 2;
      if (bus.IssueStallOut !== 1'b1) begin errors++; $display("[TB] FAIL hazard_stall: got %0h expected 1", bus.IssueStallOut); end
      tick();
      if (bus.IssueValid !== 1'b0) begin errors++; $display("[TB] FAIL hazard_noissue: got %0h expected 0", bus.IssueValid); end
      bus.CompleteValid = 1; bus.CompleteRegAddr = 4'd3;
      #1;
      checks++;
      if (bus.IssueStallOut !== 1'b1) begin errors++; $display("[TB] FAIL complete_nobypass: got %0h expected 1", bus.IssueStallOut); end
      tick();
      bus.CompleteValid = 0;
      #1;
      checks += 4;
      if (bus.PendingMask !== 16'h0) begin errors++; $display("[TB] FAIL complete_mask: got %0h expected 0", bus.PendingMask); end
      if (bus.IssueStallOut !== 1'b0) begin errors++; $display("[TB] FAIL complete_release: got %0h expected 0", bus.IssueStallOut); end
      tick();
      if (bus.IssueValid !== 1'b1 || bus.FunctionalUnitIssue !== 5'b00010) begin
         errors++; $display("[TB] FAIL hazard_issue: got %0h/%0h expected 1/2", bus.IssueValid, bus.FunctionalUnitIssue);
      end
      if (bus.PendingMask !== 16'h0) begin errors++; $display("[TB] FAIL hazard_mask_after: got %0h expected 0", bus.PendingMask); end
   endtask

   task automatic test_set_clear();
      applyStimulus();
      bus.InstValid = 1; bus.WritebackEnIn = 1; bus.WritebackRegAddr = 4'd5;
      bus.CompleteValid = 1; bus.CompleteRegAddr = 4'd5;
      tick();
      checks++;
      if (bus.PendingMask[5] !== 1'b1) begin errors++; $display("[TB] FAIL setclr_same: got %0h expected 1", bus.PendingMask[5]); end
      bus.WritebackRegAddr = 4'd7;
      tick();
      checks++;
      if (bus.PendingMask !== 16'h0080) begin errors++; $display("[TB] FAIL setclr_diff: got %0h expected 80", bus.PendingMask); end
      applyStimulus();
      bus.CompleteValid = 1; bus.CompleteRegAddr = 4'd9;
      tick();
      checks++;
      if (bus.PendingMask !== 16'h0080) begin errors++; $display("[TB] FAIL clr_nonpending: got %0h expected 80", bus.PendingMask); end
      bus.CompleteRegAddr = 4'd7;
      tick();
      applyStimulus();
   endtask

   task automatic test_unit_stall();
      applyStimulus();
      sync_rst = 0; tick(); sync_rst = 1;
      bus.InstValid = 1; bus.FunctionalUnitEnable = 5'b10000; bus.FunctionalUnitReady = 5'b01111;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.IssueStallOut !== 1'b1) begin errors++; $display("[TB] FAIL unit_stall_%0d: got %0h expected 1", i, bus.IssueStallOut); end
         tick();
      end
`ifdef ISSUE_STALL_COUNTER_EN
      checks++;
      if (bus.StallCount !== 16'd3 || expStallCount != 3) begin errors++; $display("[TB] FAIL stall_count: got %0d expected 3", bus.StallCount); end
`endif
      bus.FunctionalUnitReady = 5'b11111;
      tick();
      checks++;
      if (bus.IssueValid !== 1'b1 || bus.FunctionalUnitIssue !== 5'b10000) begin
         errors++; $display("[TB] FAIL unit_issue: got %0h/%0h expected 1/10", bus.IssueValid, bus.FunctionalUnitIssue);
      end
      applyStimulus();
      tick();
   endtask

   task automatic test_clk_en();
      logic [15:0] maskBefore;
      applyStimulus();
      bus.InstValid = 1; bus.WritebackEnIn = 1; bus.WritebackRegAddr = 4'd11; bus.MinorOpcode = 4'h3;
      tick();
      applyStimulus();
      maskBefore = bus.PendingMask;
      clk_en = 0;
      bus.InstValid = 1; bus.WritebackEnIn = 1; bus.WritebackRegAddr = 4'd2; bus.MinorOpcode = 4'hC;
      bus.CompleteValid = 1; bus.CompleteRegAddr = 4'd11;
      #1;
      checks++;
      if (bus.IssueStallOut !== 1'b1) begin errors++; $display("[TB] FAIL clken_stall: got %0h expected 1", bus.IssueStallOut); end
      tick(); tick();
      checks += 3;
      if (bus.PendingMask !== maskBefore || bus.PendingMask !== modelMask()) begin
         errors++; $display("[TB] FAIL clken_mask: got %0h expected %0h", bus.PendingMask, modelMask());
      end
      if (bus.IssueValid !== 1'b1) begin errors++; $display("[TB] FAIL clken_hold_valid: got %0h expected 1", bus.IssueValid); end
      if (bus.ALU_MinorOpcode !== 4'h3) begin errors++; $display("[TB] FAIL clken_hold_op: got %0h expected 3", bus.ALU_MinorOpcode); end
      clk_en = 1;
      applyStimulus();
      bus.CompleteValid = 1; bus.CompleteRegAddr = 4'd11;
      tick();
      applyStimulus();
   endtask

   task automatic test_reset_midissue();
      applyStimulus();
      bus.InstValid = 1; bus.WritebackEnIn = 1; bus.RegADataIn = 16'hBEEF; bus.InstructionTagIn = 6'h11;
      for (int r = 0; r < 16; r++) begin
         bus.WritebackRegAddr = 4'(r);
         tick();
      end
      checks++;
      if (bus.PendingMask !== 16'hFFFF) begin errors++; $display("[TB] FAIL fill_mask: got %0h expected ffff", bus.PendingMask); end
      bus.WritebackEnIn = 0; bus.FunctionalUnitEnable = 5'b00100;
      sync_rst = 0;
      tick();
      checks += 3;
      if (bus.PendingMask !== 16'h0) begin errors++; $display("[TB] FAIL rst_mask: got %0h expected 0", bus.PendingMask); end
      if (bus.IssueValid !== 1'b0 || bus.FunctionalUnitIssue !== 5'b0) begin
         errors++; $display("[TB] FAIL rst_inflight: got %0h/%0h expected 0/0", bus.IssueValid, bus.FunctionalUnitIssue);
      end
      if (bus.Data_A !== 16'h0 || bus.IssueTagOut !== 6'h0 || bus.RegWriteAddrOut !== 4'h0) begin
         errors++; $display("[TB] FAIL rst_payload: got %0h/%0h/%0h expected 0", bus.Data_A, bus.IssueTagOut, bus.RegWriteAddrOut);
      end
      sync_rst = 1;
      #1;
      checks += 2;
      if (bus.IssueStallOut !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_stall: got %0h expected 0", bus.IssueStallOut); end
      tick();
      if (bus.IssueValid !== 1'b1 || bus.FunctionalUnitIssue !== 5'b00100) begin
         errors++; $display("[TB] FAIL rst_first_issue: got %0h/%0h expected 1/4", bus.IssueValid, bus.FunctionalUnitIssue);
      end
      applyStimulus();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         sync_rst = ($urandom_range(0, 49) != 0);
         clk_en   = ($urandom_range(0, 9) != 0);
         bus.InstValid            = ($urandom_range(0, 3) != 0);
         bus.MinorOpcode          = 4'($urandom);
         bus.FunctionalUnitEnable = 5'($urandom) & 5'($urandom);
         bus.FunctionalUnitReady  = 5'($urandom) | 5'($urandom);
         bus.WriteBackSourceIn    = 2'($urandom);
         bus.InstructionTagIn     = 6'($urandom);
         bus.WritebackEnIn        = 1'($urandom);
         bus.WritebackRegAddr     = 4'($urandom);
         bus.RegAReadEn           = 1'($urandom);
         bus.RegBReadEn           = 1'($urandom);
         bus.RegAAddr             = 4'($urandom);
         bus.RegBAddr             = 4'($urandom);
         bus.RegADataIn           = 16'($urandom);
         bus.RegBDataIn           = 16'($urandom);
         bus.CompleteValid        = ($urandom_range(0, 2) != 0);
         bus.CompleteRegAddr      = 4'($urandom);
         #1;
         predict();
         checks++;
         if (bus.IssueStallOut !== 1'(predStall)) begin errors++; $display("[TB] FAIL rnd_stall[%0d]: got %0h expected %0h", n, bus.IssueStallOut, predStall); end
         tick();
         checks += 4;
         if (bus.IssueValid !== expIssueValid || bus.FunctionalUnitIssue !== expFuIssue || bus.RegWriteEn !== expWrEn) begin
            errors++; $display("[TB] FAIL rnd_ctrl[%0d]: got %0h/%0h/%0h expected %0h/%0h/%0h", n, bus.IssueValid, bus.FunctionalUnitIssue, bus.RegWriteEn, expIssueValid, expFuIssue, expWrEn);
         end
         if (bus.Data_A !== expDataA || bus.Data_B !== expDataB || bus.ALU_MinorOpcode !== expOpcode) begin
            errors++; $display("[TB] FAIL rnd_data[%0d]: got %0h/%0h/%0h expected %0h/%0h/%0h", n, bus.Data_A, bus.Data_B, bus.ALU_MinorOpcode, expDataA, expDataB, expOpcode);
         end
         if (bus.IssueTagOut !== expTag || bus.WriteBackSourceOut !== expWbSrc || bus.RegWriteAddrOut !== expWrAddr) begin
            errors++; $display("[TB] FAIL rnd_tag[%0d]: got %0h/%0h/%0h expected %0h/%0h/%0h", n, bus.IssueTagOut, bus.WriteBackSourceOut, bus.RegWriteAddrOut, expTag, expWbSrc, expWrAddr);
         end
         if (bus.PendingMask !== modelMask()) begin errors++; $display("[TB] FAIL rnd_mask[%0d]: got %0h expected %0h", n, bus.PendingMask, modelMask()); end
`ifdef ISSUE_STALL_COUNTER_EN
         checks++;
         if (bus.StallCount !== 16'(expStallCount)) begin errors++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", n, bus.StallCount, expStallCount); end
`endif
      end
      sync_rst = 1; clk_en = 1;
      applyStimulus();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sync_rst = 1;
      clk_en = 1;
      applyStimulus();
      test_reset();
      test_basic_issue();
      test_hazard_complete();
      test_set_clear();
      test_unit_stall();
      test_clk_en();
      test_reset_midissue();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
